conv_stream_feeder: RTL and testbench

- Transmit-side sequencer for the convolution engine's input protocol.
- Management writes 3x3 kernel coefficients and one full image frame into local buffers over a valid/ready port.
- On start, it drives the engine's kernel_write_en/kernel_in and shift_write_en/img_input pins with the contiguous, gap-free streams the engine requires.
- Sits between the management-side glue and the convolve instance; it replaces raw io_in driving.

---
 rtl/conv_stream_feeder.sv | 202 ++++++++++++++++++++
 tb/tb_conv_stream_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder
//   Buffers a 3x3 kernel and one image frame written over a valid/ready
//   config port. On start it replays them to the convolution engine as
//   gap-free streams: an optional engine reset, the kernel, the frame, and
//   then a few zero flush pixels.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   cfg_valid/cfg_ready   config handshake; cfg_sel 1 = kernel, 0 = pixel
//   cfg_data              coefficient or pixel value
//   cfg_clear             in IDLE, empty both buffers
//   start                 request one frame transmission
//   busy, done, start_err status (done/start_err are single-cycle pulses)
//   conv_reset            one-cycle engine reset ahead of a kernel resend
//   kernel_write_en/kernel_in, img_write_en/img_input   engine stream pins
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accepting config writes, waiting for start
// S_CRST  | conv_reset high for one cycle
// S_KSEND | streaming KN kernel coefficients
// S_ISEND | streaming FRAME pixels
// S_FLUSH | FLUSH_LEN zero pixels, write enable still high
// S_DONE  | done pulse, pixel buffer released
module conv_stream_feeder #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_LENGTH  = 16,
  parameter int IMG_ROWS    = 16,
  parameter int FLUSH_LEN   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cfg_valid,
  input  logic            cfg_sel,
  input  logic [BITS-1:0] cfg_data,
  output logic            cfg_ready,
  input  logic            cfg_clear,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            start_err,
  output logic            conv_reset,
  output logic            kernel_write_en,
  output logic [BITS-1:0] kernel_in,
  output logic            img_write_en,
  output logic [BITS-1:0] img_input
);

  localparam int KN    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int FRAME = IMG_LENGTH * IMG_ROWS;
  localparam int KC_W  = $clog2(KN + 1);
  localparam int PC_W  = $clog2(FRAME + 1);
  localparam int KA_W  = $clog2(KN);
  localparam int PA_W  = $clog2(FRAME);

  localparam logic [KC_W-1:0] K_FULL = KC_W'(KN);
  localparam logic [PC_W-1:0] P_FULL = PC_W'(FRAME);
  localparam logic [PC_W-1:0] K_LAST = PC_W'(KN - 1);
  localparam logic [PC_W-1:0] P_LAST = PC_W'(FRAME - 1);
  localparam logic [PC_W-1:0] F_LAST = PC_W'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_KSEND, S_ISEND, S_FLUSH, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] idx, idx_nxt;
  logic [KC_W-1:0] kcnt;
  logic [PC_W-1:0] pcnt;
  logic            kdirty;
  logic            start_err_nxt;
  logic            kwe_nxt, iwe_nxt;
  logic [BITS-1:0] kin_nxt, iin_nxt;
  logic            wr_ok;

  logic [BITS-1:0] kbuf [KN];
  logic [BITS-1:0] pbuf [FRAME];

  // A full buffer deasserts ready, so a write can never overwrite.
  assign cfg_ready = (state == S_IDLE) && (cfg_sel ? (kcnt < K_FULL) : (pcnt < P_FULL));
  assign wr_ok     = cfg_valid && cfg_ready && !cfg_clear;

  always_ff @(posedge clk) begin
    if (wr_ok && cfg_sel)  kbuf[kcnt[KA_W-1:0]] <= cfg_data;
    if (wr_ok && !cfg_sel) pbuf[pcnt[PA_W-1:0]] <= cfg_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kcnt   <= '0;
      pcnt   <= '0;
      kdirty <= 1'b1;
    end else if (state == S_IDLE && cfg_clear) begin
      kcnt   <= '0;
      pcnt   <= '0;
      kdirty <= 1'b1;
    end else begin
      if (wr_ok && cfg_sel) begin
        kcnt   <= kcnt + 1'b1;
        kdirty <= 1'b1;
      end
      if (wr_ok && !cfg_sel) pcnt <= pcnt + 1'b1;
      // Kernel is retained across frames; only the pixels are released.
      if (state == S_DONE) begin
        pcnt   <= '0;
        kdirty <= 1'b0;
      end
    end
  end

  // Output values are derived from the next state so that every engine pin
  // comes straight from a flop yet lines up with the state it belongs to.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    start_err_nxt = 1'b0;
    kwe_nxt       = 1'b0;
    kin_nxt       = '0;
    iwe_nxt       = 1'b0;
    iin_nxt       = '0;
    unique case (state)
      S_IDLE: begin
        if (!cfg_clear && start) begin
          if (kcnt == K_FULL && pcnt == P_FULL) begin
            state_nxt = kdirty ? S_CRST : S_ISEND;
            idx_nxt   = '0;
          end else begin
            start_err_nxt = 1'b1;
          end
        end
      end
      S_CRST: begin
        state_nxt = S_KSEND;
        idx_nxt   = '0;
      end
      S_KSEND: begin
        if (idx == K_LAST) begin
          state_nxt = S_ISEND;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      S_ISEND: begin
        if (idx == P_LAST) begin
          state_nxt = (FLUSH_LEN == 0) ? S_DONE : S_FLUSH;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      S_FLUSH: begin
        if (idx == F_LAST) begin
          state_nxt = S_DONE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt == S_KSEND) begin
      kwe_nxt = 1'b1;
      kin_nxt = kbuf[idx_nxt[KA_W-1:0]];
    end
    if (state_nxt == S_ISEND) begin
      iwe_nxt = 1'b1;
      iin_nxt = pbuf[idx_nxt[PA_W-1:0]];
    end
    if (state_nxt == S_FLUSH) iwe_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      idx             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      start_err       <= 1'b0;
      conv_reset      <= 1'b0;
      kernel_write_en <= 1'b0;
      kernel_in       <= '0;
      img_write_en    <= 1'b0;
      img_input       <= '0;
    end else begin
      state           <= state_nxt;
      idx             <= idx_nxt;
      busy            <= (state_nxt != S_IDLE);
      done            <= (state_nxt == S_DONE);
      start_err       <= start_err_nxt;
      conv_reset      <= (state_nxt == S_CRST);
      kernel_write_en <= kwe_nxt;
      kernel_in       <= kin_nxt;
      img_write_en    <= iwe_nxt;
      img_input       <= iin_nxt;
    end
  end

endmodule

// File: tb/tb_conv_stream_feeder.sv
module tb_conv_stream_feeder;
  localparam int BITS      = 9;
  localparam int KN        = 9;
  localparam int FRAME     = 256;
  localparam int FLUSH_LEN = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cfg_valid = 1'b0, cfg_sel = 1'b0, cfg_clear = 1'b0, start = 1'b0;
  logic [BITS-1:0] cfg_data = '0;
  logic            cfg_ready, busy, done, start_err, conv_reset;
  logic            kernel_write_en, img_write_en;
  logic [BITS-1:0] kernel_in, img_input;

  conv_stream_feeder dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_clear(cfg_clear), .start(start),
    .busy(busy), .done(done), .start_err(start_err), .conv_reset(conv_reset),
    .kernel_write_en(kernel_write_en), .kernel_in(kernel_in),
    .img_write_en(img_write_en), .img_input(img_input)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: buffer contents as queues plus the "kernel needs resend" flag.
  logic [BITS-1:0] mk[$];
  logic [BITS-1:0] mp[$];
  bit              mdirty = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuity / exclusivity / zero-data monitor
  int krun = 0, irun = 0;
  bit kprev = 1'b0, iprev = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      krun = 0; irun = 0; kprev = 1'b0; iprev = 1'b0;
    end else begin
      chk("enables_overlap", int'(kernel_write_en & img_write_en), 0);
      if (!kernel_write_en) chk("kernel_in_nonzero_idle", int'(kernel_in), 0);
      if (!img_write_en)    chk("img_input_nonzero_idle", int'(img_input), 0);
      if (kernel_write_en) krun++;
      else if (kprev) begin chk("kernel_we_run_length", krun, KN); krun = 0; end
      if (img_write_en) irun++;
      else if (iprev) begin chk("img_we_run_length", irun, FRAME + FLUSH_LEN); irun = 0; end
      kprev = kernel_write_en;
      iprev = img_write_en;
    end
  end

  // Entered one edge after start was accepted, at edge+1.
  task automatic run_frame();
    int n, crst_cnt, crst_edge, first_pix, done_edge, exp_done;
    bit ready_seen;
    logic [BITS-1:0] kq[$], iq[$], ek[$], ei[$];
    crst_cnt = 0; crst_edge = -1; first_pix = -1; done_edge = -1; ready_seen = 1'b0;
    exp_done = (mdirty ? 1 + KN : 0) + FRAME + FLUSH_LEN + 1;
    cfg_valid = 1'b1; cfg_sel = 1'($urandom); cfg_data = BITS'($urandom);
    n = 1;
    while (done_edge < 0 && n <= 400) begin
      if (conv_reset) begin crst_cnt++; crst_edge = n; end
      if (kernel_write_en) kq.push_back(kernel_in);
      if (img_write_en) begin
        if (first_pix < 0) first_pix = n;
        iq.push_back(img_input);
      end
      if (cfg_ready) ready_seen = 1'b1;
      if (done) done_edge = n;
      if (done_edge < 0) begin @(posedge clk); #1; n++; end
    end
    cfg_valid = 1'b0;
    chk("done_edge", done_edge, exp_done);
    chk("conv_reset_count", crst_cnt, mdirty ? 1 : 0);
    if (mdirty) chk("conv_reset_edge", crst_edge, 1);
    chk("first_pixel_edge", first_pix, mdirty ? 2 + KN : 1);
    chk("cfg_ready_while_busy", int'(ready_seen), 0);
    if (mdirty) ek = mk;
    ei = mp;
    for (int i = 0; i < FLUSH_LEN; i++) ei.push_back('0);
    chk("kernel_stream_len", kq.size(), ek.size());
    for (int i = 0; i < kq.size() && i < ek.size(); i++)
      chk($sformatf("kernel_in[%0d]", i), int'(kq[i]), int'(ek[i]));
    chk("img_stream_len", iq.size(), ei.size());
    for (int i = 0; i < iq.size() && i < ei.size(); i++)
      chk($sformatf("img_input[%0d]", i), int'(iq[i]), int'(ei[i]));
    @(posedge clk); #1;
    chk("busy_after_done", int'(busy), 0);
    chk("done_width", int'(done), 0);
    mp.delete();
    mdirty = 1'b0;
  endtask

  // One IDLE-side cycle: drive at edge+1, check ready before the edge and
  // status after it; hands over to run_frame when the model accepts start.
  task automatic step(input bit v, input bit s, input logic [BITS-1:0] d,
                      input bit c, input bit st);
    bit exp_ready, acc, exp_err;
    cfg_valid = v; cfg_sel = s; cfg_data = d; cfg_clear = c; start = st;
    exp_ready = s ? (mk.size() < KN) : (mp.size() < FRAME);
    #2 chk("cfg_ready", int'(cfg_ready), int'(exp_ready));
    acc = 1'b0; exp_err = 1'b0;
    if (c) begin
      mk.delete(); mp.delete(); mdirty = 1'b1;
    end else begin
      if (st) begin
        if (mk.size() == KN && mp.size() == FRAME) acc = 1'b1;
        else exp_err = 1'b1;
      end
      if (v && exp_ready) begin
        if (s) begin mk.push_back(d); mdirty = 1'b1; end
        else mp.push_back(d);
      end
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_clear = 1'b0; start = 1'b0;
    chk("start_err", int'(start_err), int'(exp_err));
    chk("busy", int'(busy), int'(acc));
    if (acc) run_frame();
  endtask

  typedef struct {
    bit v; bit s; logic [BITS-1:0] d; bit c; bit st;
    bit exp_ready; bit exp_err;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int seen, guard;
    bit rv, rs, rc, rst;

    tbl[0] = '{1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1};  // start, both empty
    tbl[3] = '{1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 9'd7, 1'b0, 1'b0, 1'b1, 1'b0};  // one kernel write
    tbl[5] = '{1'b1, 1'b0, 9'd3, 1'b0, 1'b1, 1'b1, 1'b1};  // pixel write + early start
    tbl[6] = '{1'b1, 1'b0, 9'd4, 1'b1, 1'b1, 1'b1, 1'b0};  // clear beats write and start
    tbl[7] = '{1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1};  // buffers empty again
    tbl[8] = '{1'b0, 1'b1, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_start_err", int'(start_err), 0);
    chk("rst_conv_reset", int'(conv_reset), 0);
    chk("rst_kernel_we", int'(kernel_write_en), 0);
    chk("rst_img_we", int'(img_write_en), 0);
    chk("rst_kernel_in", int'(kernel_in), 0);
    chk("rst_img_input", int'(img_input), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cfg_valid = tbl[i].v; cfg_sel = tbl[i].s; cfg_data = tbl[i].d;
      cfg_clear = tbl[i].c; start = tbl[i].st;
      #2 chk($sformatf("tbl%0d_ready", i), int'(cfg_ready), int'(tbl[i].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_start_err", i), int'(start_err), int'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_busy", i), int'(busy), 0);
    end
    cfg_valid = 1'b0; cfg_clear = 1'b0; start = 1'b0;
    mk.delete(); mp.delete(); mdirty = 1'b1;

    // Frame 1: k = 1..9, pixels 0..255, then overflow attempts.
    for (int i = 0; i < KN; i++) step(1'b1, 1'b1, BITS'(i + 1), 1'b0, 1'b0);
    for (int j = 0; j < FRAME; j++) step(1'b1, 1'b0, BITS'(j), 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'h1AA, 1'b0, 1'b0);
    step(1'b1, 1'b0, 9'h155, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Frame 2: kernel retained; early start at 255 pixels must be refused.
    for (int j = 0; j < FRAME - 1; j++) step(1'b1, 1'b0, BITS'($urandom), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0, BITS'($urandom), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Reset at pixel 100 of the image stream.
    for (int j = 0; j < FRAME; j++) step(1'b1, 1'b0, BITS'($urandom), 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0; guard = 0;
    while (seen < 100 && guard < 400) begin
      if (img_write_en) seen++;
      if (seen < 100) begin @(posedge clk); #1; guard++; end
    end
    chk("abort_reached_pixel100", seen, 100);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_img_we", int'(img_write_en), 0);
    chk("abort_img_input", int'(img_input), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk); @(posedge clk); #1;
    chk("abort_no_done", int'(done), 0);
    reset_n = 1'b1;
    mk.delete(); mp.delete(); mdirty = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      rv  = ($urandom_range(7) != 0);
      rs  = ($urandom_range(5) == 0);
      rc  = ($urandom_range(599) == 0);
      rst = ($urandom_range(24) == 0);
      step(rv, rs, BITS'($urandom), rc, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
